// File: rtl/tmds_pkg.sv
// TMDS channel decoder shared definitions: control tokens, TERC4 table, lock FSM states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a. The TERC4 table exists only when TMDS_TERC4_EN is defined.
package tmds_pkg;

  // Blanking control tokens, indexed by the {C1,C0} value they carry
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

`ifdef TMDS_TERC4_EN
  // HDMI data-island codes; entry i is the symbol that carries nibble i
  localparam logic [15:0][9:0] TERC4_CODES = {
    10'b1011000011,  // F
    10'b0101100011,  // E
    10'b1001110001,  // D
    10'b1010001110,  // C
    10'b1011000110,  // B
    10'b0110011100,  // A
    10'b0100111001,  // 9
    10'b1011001100,  // 8
    10'b0100111100,  // 7
    10'b0110001110,  // 6
    10'b0100011110,  // 5
    10'b0101110001,  // 4
    10'b1011100010,  // 3
    10'b1011100100,  // 2
    10'b1001100011,  // 1
    10'b1010011100   // 0
  };
`endif

  function automatic logic is_ctrl_token(input logic [9:0] s);
    return (s == CTRL_TOKEN_00) || (s == CTRL_TOKEN_01) ||
           (s == CTRL_TOKEN_10) || (s == CTRL_TOKEN_11);
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Pure combinational 10b symbol decode: video byte, control bits and (TMDS_TERC4_EN) TERC4 nibble.
// Latency: 0 cycles; sits between the stage1 and stage2 registers of the channel decoder.
// Backpressure: none; evaluates whatever symbol is presented.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic [7:0] data,
  output logic [1:0] ctrl
`ifdef TMDS_TERC4_EN
  ,
  output logic       is_terc4,
  output logic [3:0] terc4
`endif
);

  logic [7:0] d;

  // Undo the optional inversion carried in bit 9
  assign d = sym[9] ? ~sym[7:0] : sym[7:0];

  // Undo the XOR/XNOR transition chain selected by bit 8
  always_comb begin
    data    = '0;
    data[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Control bits for the four tokens; meaningless for any other symbol
  always_comb begin
    case (sym)
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       ctrl = 2'b00;
    endcase
  end

`ifdef TMDS_TERC4_EN
  // Table search for data-island symbols
  always_comb begin
    is_terc4 = 1'b0;
    terc4    = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (sym == TERC4_CODES[i]) begin
        is_terc4 = 1'b1;
        terc4    = 4'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: word alignment from control tokens, lock tracking, 10b->8b decode.
// Latency: a word is on the outputs 3 cycles after it is presented (prev_word, stage1, stage2).
// Backpressure: none; one word accepted every clk_pixel. Option macro: TMDS_TERC4_EN.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOCK_COUNT    = 8,
  parameter int LOSS_TIMEOUT  = 4096
) (
  input  logic       clk_pixel,
  input  logic       sys_resetn,
  input  logic [9:0] tmds_word,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic       slip
`ifdef TMDS_TERC4_EN
  ,
  output logic       is_terc4,
  output logic [3:0] terc4
`endif
);

  localparam int MAX_A = (SEARCH_WINDOW > LOCK_COUNT) ? SEARCH_WINDOW : LOCK_COUNT;
  localparam int MAX_P = (MAX_A > LOSS_TIMEOUT) ? MAX_A : LOSS_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SEARCH_WINDOW - 1);
  localparam logic [CNT_W-1:0] LT_LAST  = CNT_W'(LOSS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LC_LAST  = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] LC_FULL  = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [9:0]       prev_word;
  logic [19:0]      win;
  logic [9:0]       sym;
  logic [9:0]       s1_sym;
  logic             s1_tok;
  state_t           state;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] timer;
  logic [7:0]       dec_data;
  logic [1:0]       dec_ctrl;
`ifdef TMDS_TERC4_EN
  logic             dec_is_terc4;
  logic [3:0]       dec_terc4;
`endif

  // Offset 0 picks prev_word; larger offsets borrow low bits of the newer word
  assign win = {tmds_word, prev_word};
  assign sym = 10'(win >> bit_offset);

  // Lock status is the FSM state, which already moves in step with stage2
  assign locked = (state == LOCKED);
  assign de     = locked & ~is_ctrl;

  tmds_symbol_decode u_decode (
    .sym      (s1_sym),
    .data     (dec_data),
    .ctrl     (dec_ctrl)
`ifdef TMDS_TERC4_EN
    ,
    .is_terc4 (dec_is_terc4),
    .terc4    (dec_terc4)
`endif
  );

  // Previous word, stage1 symbol/token flag and stage2 decoded outputs
  always_ff @(posedge clk_pixel or negedge sys_resetn) begin
    if (!sys_resetn) begin
      prev_word <= '0;
      s1_sym    <= '0;
      s1_tok    <= 1'b0;
      data      <= '0;
      ctrl      <= '0;
      is_ctrl   <= 1'b0;
`ifdef TMDS_TERC4_EN
      is_terc4  <= 1'b0;
      terc4     <= '0;
`endif
    end else begin
      prev_word <= tmds_word;
      s1_sym    <= sym;
      s1_tok    <= is_ctrl_token(sym);
      data      <= dec_data;
      is_ctrl   <= s1_tok;
      if (s1_tok) begin
        ctrl <= dec_ctrl;
      end
`ifdef TMDS_TERC4_EN
      is_terc4  <= dec_is_terc4;
      terc4     <= dec_terc4;
`endif
    end
  end

  // Alignment FSM: count token runs, slip offset on search timeout, drop lock on token loss
  always_ff @(posedge clk_pixel or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state      <= SEARCH;
      run        <= '0;
      timer      <= '0;
      bit_offset <= 4'd0;
      slip       <= 1'b0;
    end else begin
      slip <= 1'b0;
      case (state)
        SEARCH: begin
          if (s1_tok) begin
            // A token beats a coincident timeout: it counts and suppresses the slip
            if (run == LC_LAST) begin
              state <= LOCKED;
              run   <= LC_FULL;
              timer <= '0;
            end else begin
              run <= run + CNT_ONE;
              if (timer != SW_LAST) begin
                timer <= timer + CNT_ONE;
              end
            end
          end else begin
            run <= '0;
            if (timer == SW_LAST) begin
              timer      <= '0;
              slip       <= 1'b1;
              bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
            end else begin
              timer <= timer + CNT_ONE;
            end
          end
        end
        LOCKED: begin
          if (s1_tok) begin
            timer <= '0;
          end else if (timer == LT_LAST) begin
            state <= SEARCH;
            run   <= '0;
            timer <= '0;
          end else begin
            timer <= timer + CNT_ONE;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: stimulus queues expected outputs per cycle,
// a negedge monitor compares them when that cycle is presented.
// Option macro: TMDS_TERC4_EN adds the data-island checks.
module tb_tmds_channel_decoder;

  logic       clk_pixel = 1'b0;
  logic       sys_resetn = 1'b1;
  logic [9:0] tmds_word = '0;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       is_ctrl;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;
  logic       slip;
`ifdef TMDS_TERC4_EN
  logic       is_terc4;
  logic [3:0] terc4;
`endif

  tmds_channel_decoder dut (
    .clk_pixel  (clk_pixel),
    .sys_resetn (sys_resetn),
    .tmds_word  (tmds_word),
    .data       (data),
    .ctrl       (ctrl),
    .is_ctrl    (is_ctrl),
    .de         (de),
    .locked     (locked),
    .bit_offset (bit_offset),
    .slip       (slip)
`ifdef TMDS_TERC4_EN
    ,
    .is_terc4   (is_terc4),
    .terc4      (terc4)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  localparam logic [9:0] VID0 = 10'b0100000000;
  // TOK0 delivered 3 bits late: low 3 bits hold the previous symbol's top bits
  localparam logic [9:0] SH3  = {TOK0[6:0], TOK0[9:7]};

  logic [9:0] vid_w [6] = '{10'b0100000000, 10'b0100000001, 10'b0000000001,
                            10'b0011111111, 10'b1100001111, 10'b1010011100};
  logic [7:0] vid_d [6] = '{8'h00, 8'h03, 8'hFD, 8'hFF, 8'h10, 8'h5B};

  typedef struct {
    int         at;
    string      name;
    logic [8:0] mask;  // data,ctrl,is_ctrl,de,locked,offset,slip,is_terc4,terc4
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       is_ctrl;
    logic       de;
    logic       locked;
    logic [3:0] off;
    logic       slip;
    logic       is_terc4;
    logic [3:0] terc4;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int base;

  function automatic void push(int at, string name, logic [8:0] mask, logic [7:0] d,
                               logic [1:0] c, logic ic, logic de_e, logic lk,
                               logic [3:0] off, logic sl, logic it, logic [3:0] t);
    exp_t e;
    e.at = at; e.name = name; e.mask = mask; e.data = d; e.ctrl = c; e.is_ctrl = ic;
    e.de = de_e; e.locked = lk; e.off = off; e.slip = sl; e.is_terc4 = it; e.terc4 = t;
    sb.push_back(e);
  endfunction

  function automatic void exp_reset(int at, string name);
    push(at, name, 9'h1FF, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'h0);
  endfunction

  function automatic void exp_video(int at, string name, logic [7:0] d, logic [1:0] c);
    push(at, name, 9'h09F, d, c, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'h0);
  endfunction

  function automatic void exp_ctrl(int at, string name, logic [1:0] c, logic lk);
    push(at, name, 9'h01E, 8'h00, c, 1'b1, 1'b0, lk, 4'd0, 1'b0, 1'b0, 4'h0);
  endfunction

  function automatic void exp_status(int at, string name, logic lk, logic [3:0] off, logic sl);
    push(at, name, 9'h070, 8'h00, 2'b00, 1'b0, 1'b0, lk, off, sl, 1'b0, 4'h0);
  endfunction

  function automatic void cmp(string name, string field, logic [7:0] act, logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s at cycle %0d: got %0h, expected %0h", name, field, cyc, act, expv);
    end
  endfunction

  function automatic void check_entry(exp_t e);
    if (e.mask[0]) cmp(e.name, "data", data, e.data);
    if (e.mask[1]) cmp(e.name, "ctrl", {6'd0, ctrl}, {6'd0, e.ctrl});
    if (e.mask[2]) cmp(e.name, "is_ctrl", {7'd0, is_ctrl}, {7'd0, e.is_ctrl});
    if (e.mask[3]) cmp(e.name, "de", {7'd0, de}, {7'd0, e.de});
    if (e.mask[4]) cmp(e.name, "locked", {7'd0, locked}, {7'd0, e.locked});
    if (e.mask[5]) cmp(e.name, "bit_offset", {4'd0, bit_offset}, {4'd0, e.off});
    if (e.mask[6]) cmp(e.name, "slip", {7'd0, slip}, {7'd0, e.slip});
`ifdef TMDS_TERC4_EN
    if (e.mask[7]) cmp(e.name, "is_terc4", {7'd0, is_terc4}, {7'd0, e.is_terc4});
    if (e.mask[8]) cmp(e.name, "terc4", {4'd0, terc4}, {4'd0, e.terc4});
`endif
  endfunction

  // Monitor: compare every expectation due in the current cycle, flag any that was skipped
  always @(negedge clk_pixel) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_entry(sb[i]);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                 sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic step(input logic [9:0] w);
    @(posedge clk_pixel);
    #1;
    tmds_word = w;
  endtask

  initial begin
    // ---------------- Phase A: reset, aligned lock, video decode, loss of lock
    #2 sys_resetn = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1;
    exp_reset(cyc, "reset_state");
    @(posedge clk_pixel);
    #1;
    sys_resetn = 1'b1;
    tmds_word  = TOK0;
    base       = cyc;
    for (int j = 1; j < 8; j++) step(TOK0);
    exp_ctrl(base + 9, "t1_seven_tokens", 2'b00, 1'b0);
    exp_ctrl(base + 10, "t1_lock", 2'b00, 1'b1);
    exp_status(base + 10, "t1_offset", 1'b1, 4'd0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step(vid_w[j]);
      if (j == 5) begin
        push(cyc + 3, "t1_island_data", 9'h01F, vid_d[j], 2'b00, 1'b0, 1'b1, 1'b1,
             4'd0, 1'b0, 1'b0, 4'h0);
`ifdef TMDS_TERC4_EN
        push(cyc + 3, "t6_terc4", 9'h188, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1,
             4'd0, 1'b0, 1'b1, 4'h0);
`endif
      end else begin
        exp_video(cyc + 3, $sformatf("t1_video%0d", j), vid_d[j], 2'b00);
      end
    end
    exp_video(base + 4105, "t3_before_timeout", 8'h00, 2'b00);
    push(base + 4106, "t3_timeout", 9'h078, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0,
         4'd0, 1'b0, 1'b0, 4'h0);
    while (cyc < base + 4108) step(VID0);

    // ---------------- Phase B: stream 3 bits late, three slips then lock; async reset
    @(posedge clk_pixel);
    #1;
    sys_resetn = 1'b0;
    tmds_word  = SH3;
    exp_reset(cyc, "reset_between");
    repeat (2) step(SH3);
    @(posedge clk_pixel);
    #1;
    sys_resetn = 1'b1;
    base       = cyc;
    exp_status(base + 1023, "t2_before_slip1", 1'b0, 4'd0, 1'b0);
    exp_status(base + 1024, "t2_slip1", 1'b0, 4'd1, 1'b1);
    exp_status(base + 1025, "t2_slip1_pulse_end", 1'b0, 4'd1, 1'b0);
    exp_status(base + 2048, "t2_slip2", 1'b0, 4'd2, 1'b1);
    exp_status(base + 3072, "t2_slip3", 1'b0, 4'd3, 1'b1);
    exp_status(base + 3080, "t2_before_lock", 1'b0, 4'd3, 1'b0);
    exp_status(base + 3081, "t2_lock", 1'b1, 4'd3, 1'b0);
    exp_ctrl(base + 3081, "t2_lock_ctrl", 2'b00, 1'b1);
    exp_status(base + 3084, "t5_locked_pre_reset", 1'b1, 4'd3, 1'b0);
    while (cyc < base + 3084) step(SH3);
    @(posedge clk_pixel);
    #3;
    exp_reset(cyc, "t5_async_reset");
    sys_resetn = 1'b0;

    // ---------------- Phase C: token run completing on the search-timeout cycle
    repeat (2) step(VID0);
    @(posedge clk_pixel);
    #1;
    sys_resetn = 1'b1;
    tmds_word  = VID0;
    base       = cyc;
    exp_ctrl(base + 1017, "t4_ctrl10", 2'b10, 1'b0);
    exp_ctrl(base + 1022, "t4_ctrl11", 2'b11, 1'b0);
    exp_ctrl(base + 1023, "t4_ctrl00", 2'b00, 1'b0);
    exp_status(base + 1023, "t4_before_timeout", 1'b0, 4'd0, 1'b0);
    exp_ctrl(base + 1024, "t4_ctrl01_lock", 2'b01, 1'b1);
    exp_status(base + 1024, "t4_no_slip", 1'b1, 4'd0, 1'b0);
    exp_video(base + 1025, "t4_ctrl_hold", 8'h00, 2'b01);
    exp_video(base + 1026, "t4_video_fd", 8'hFD, 2'b01);
    while (cyc < base + 1013) step(VID0);
    repeat (5) step(TOK2);
    step(TOK3);
    step(TOK0);
    step(TOK1);
    step(VID0);
    step(10'b0000000001);
    while (cyc < base + 1030) step(VID0);

    repeat (3) @(posedge clk_pixel);
    #1;
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
